phy_rx_lane_align: RTL and testbench
====================================

# phy_rx_lane_align

Receive-side lane front end of the PHY: consumes one serial lane from `phy_tx` (MSB-first bit stream, one bit per `clk_32f` cycle). It finds byte alignment by hunting for the `0xBC` comma, and declares the lane active after a run of consecutive aligned commas. Once active, it emits one parallel byte per 8 cycles with a strobe and a valid flag. Two instances (one per lane) feed the `phy_rx` unstriping/parallel-to-32-bit stage.

## Interface
Parameters:
- `BC_LOCK`, 4: consecutive aligned commas required to go active (legal range 1..7).
- `COMMA`, 8'hBC: alignment/comma symbol.
- `IDLE`, 8'h7C: idle symbol sent by TX when upstream data is invalid.

Ports:
- `clk_32f`  in  1  bit clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  1  serial lane bit, sampled every rising edge.
- `data_out`  out  8  last received byte, held between strobes.
- `valid_out`  out  1  `data_out` carries payload (not `COMMA`, not `IDLE`); held with `data_out`.
- `byte_stb`  out  1  one-cycle pulse; `data_out`/`valid_out` were updated on this edge.
- `active`  out  1  lane aligned and locked.

## Operation
- Shift register: `sr_next = {sr[6:0], data_in}`, updated every cycle in every state.
- Reset (async, immediate, also mid-byte): state=SEARCH, `sr`=0, `bit_cnt`=0, `bc_cnt`=0, `data_out`=0, `valid_out`=0, `byte_stb`=0, `active`=0.
- **SEARCH:** every edge compare `sr_next` with `COMMA`.
  - On match: `bit_cnt`<=0 and `bc_cnt`<=1.
  - If `BC_LOCK`==1, go directly to ACTIVE; otherwise go to ALIGN.
  - Any bit offset is acceptable.
- **ALIGN:** `bit_cnt` increments mod 8. At the edge with `bit_cnt`==7 (byte boundary):
  - `sr_next`==`COMMA` and `bc_cnt`+1==`BC_LOCK`: go to ACTIVE.
  - `sr_next`==`COMMA` otherwise: `bc_cnt`++ and stay in ALIGN.
  - Any other byte: go to SEARCH with `bc_cnt`<=0. The failing byte itself is not re-checked as a comma.
- **ACTIVE:** `bit_cnt` increments mod 8. At each byte boundary:
  - `data_out`<=`sr_next` and `byte_stb`<=1.
  - `valid_out`<=(`sr_next`!=`COMMA` && `sr_next`!=`IDLE`).
  - ACTIVE is exited only by `reset`; there is no in-band loss-of-sync.
- The comma that completes lock is not emitted. The first strobe comes at the next byte boundary.
- `active` = (state==ACTIVE), registered.
- `byte_stb` is 0 on every cycle other than byte boundaries in ACTIVE. It is never asserted in SEARCH or ALIGN.
- Counter widths: `bit_cnt` is 3 bits and wraps naturally. `bc_cnt` is 3 bits and never exceeds `BC_LOCK`.

## Timing
- Byte latency: the last bit of a byte is sampled at edge k. `data_out`, `valid_out` and `byte_stb` are visible after edge k, and `byte_stb` drops after edge k+1.
- Strobe period is exactly 8 cycles once active.
- Lock timing: a comma completes at edge k in SEARCH. The next `BC_LOCK`-1 commas complete at edges k+8, k+16, …. `active` rises after edge k+8·(`BC_LOCK`-1).
- ALIGN failure: SEARCH is resumed on the boundary edge. A comma whose last bit arrives at edge k+1 can be detected.

## Structure
- Shared package `phy_pkg` holds:
  - the `COMMA_BC` (8'hBC) and `IDLE_7C` (8'h7C) constants, also used by `phy_tx`;
  - the state encoding: SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2.
- Single module with no sub-module. The shift register, counters and FSM are small enough to keep flat.

## Test plan
- Reset: assert `reset` for 3 cycles with random `data_in` -> all outputs 0; `active`=0.
- Lock from offset: 3 junk bits (1,0,1), then 4×`0xBC`, then `0xA5` -> `active` rises after the last bit of the 4th BC. 8 cycles later: `byte_stb`=1 for one cycle, `data_out`=`0xA5`, `valid_out`=1.
- ALIGN abort: 2×`0xBC`, `0x55`, then 4×`0xBC`, then `0x3C` -> `active` stays 0 through `0x55`; lock occurs on the second run; `data_out`=`0x3C` with `valid_out`=1.
- Control symbols in ACTIVE: `0x7C`, `0xBC`, `0x00` -> three strobes 8 cycles apart with `data_out`=`0x7C`/`0xBC`/`0x00` and `valid_out`=0/0/1.
- Reset mid-byte in ACTIVE (after bit 4 of a byte): all outputs 0 immediately. After release, `0x11` gives no strobe; lock again only after 4 new BCs.
- `BC_LOCK`=1: a single `0xBC` -> `active`=1 on that edge; the next byte `0xC3` strobes 8 cycles later with `valid_out`=1.

Source files
------------

// File: rtl/phy_pkg.sv
// Constants and state encoding shared by the PHY transmit and receive lanes.
package phy_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;
  localparam logic [7:0] IDLE_7C  = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_lane_align.sv
// Serial lane receiver: hunts for the comma at any bit offset, locks after a
// run of byte-aligned commas, then emits one parallel byte every 8 bit clocks.
module phy_rx_lane_align
  import phy_pkg::*;
#(
  parameter int unsigned BC_LOCK = 4,
  parameter logic [7:0]  COMMA   = COMMA_BC,
  parameter logic [7:0]  IDLE    = IDLE_7C
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  localparam logic [2:0] BC_LOCK_W = 3'(BC_LOCK);

  rx_state_e  state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_q, valid_d;
  logic       stb_q, stb_d;
  logic       active_q, active_d;

  always_comb begin
    sr_d       = {sr_q[6:0], data_in};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bc_cnt_d   = bc_cnt_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    stb_d      = 1'b0;

    case (state_q)
      SEARCH: begin
        if (sr_d == COMMA) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 3'd1;
          state_d   = (BC_LOCK == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (sr_d == COMMA) begin
            bc_cnt_d = bc_cnt_q + 3'd1;
            if (bc_cnt_q + 3'd1 == BC_LOCK_W) state_d = ACTIVE;
          end else begin
            // The failed byte is dropped; hunting restarts on the next bit.
            bc_cnt_d = 3'd0;
            state_d  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_out_d = sr_d;
          valid_d    = (sr_d != COMMA) && (sr_d != IDLE);
          stb_d      = 1'b1;
        end
      end
      default: begin
        state_d  = SEARCH;
        bc_cnt_d = 3'd0;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= 8'd0;
      bit_cnt_q  <= 3'd0;
      bc_cnt_q   <= 3'd0;
      data_out_q <= 8'd0;
      valid_q    <= 1'b0;
      stb_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      stb_q      <= stb_d;
      active_q   <= active_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule

// File: tb/tb_phy_rx_lane_align.sv
// Directed bench for the lane aligner: a BC_LOCK=4 lane and a BC_LOCK=1 lane
// share one serial stream and reset.
module tb_phy_rx_lane_align;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;

  logic [7:0] data_out, data_out1;
  logic       valid_out, valid_out1;
  logic       byte_stb, byte_stb1;
  logic       active, active1;

  int n_checks = 0;
  int n_fail   = 0;
  logic stb_mid;

  always #5 clk_32f = ~clk_32f;

  phy_rx_lane_align #(.BC_LOCK(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .byte_stb (byte_stb),
    .active   (active)
  );

  phy_rx_lane_align #(.BC_LOCK(1)) dut1 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out1),
    .valid_out(valid_out1),
    .byte_stb (byte_stb1),
    .active   (active1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let the rising edge take it, and sample 1 time unit later.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Sends a byte MSB first; stb_mid collects any strobe seen on bits 1..7.
  task automatic send_byte(input logic [7:0] b);
    stb_mid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i != 0) stb_mid = stb_mid | byte_stb;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 0);
    check("rst_stb", byte_stb, 0);
    check("rst_active", active, 0);
    check("rst_active1", active1, 0);

    // Lock from a 3-bit offset
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int n = 1; n <= 4; n++) begin
      send_byte(8'hBC);
      check($sformatf("lock_active_bc%0d", n), active, (n == 4) ? 1 : 0);
    end
    check("lock_comma_not_emitted", byte_stb, 0);
    send_byte(8'hA5);
    check("a5_no_early_stb", stb_mid, 0);
    check("a5_stb", byte_stb, 1);
    check("a5_data", data_out, 8'hA5);
    check("a5_valid", valid_out, 1);

    // Control symbols while active
    send_byte(8'h7C);
    check("idle_stb_gap", stb_mid, 0);
    check("idle_stb", byte_stb, 1);
    check("idle_data", data_out, 8'h7C);
    check("idle_valid", valid_out, 0);
    send_byte(8'hBC);
    check("comma_stb_gap", stb_mid, 0);
    check("comma_data", data_out, 8'hBC);
    check("comma_valid", valid_out, 0);
    send_byte(8'h00);
    check("zero_stb", byte_stb, 1);
    check("zero_data", data_out, 8'h00);
    check("zero_valid", valid_out, 1);
    send_byte(8'h5A);
    check("5a_data", data_out, 8'h5A);

    // Asynchronous reset after bit 4 of a byte
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("pre_rst_active", active, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_stb", byte_stb, 0);
    check("mid_rst_active", active, 0);
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    send_byte(8'h11);
    check("post_rst_11_stb", stb_mid | byte_stb, 0);
    check("post_rst_11_active", active, 0);
    for (int n = 1; n <= 4; n++) begin
      send_byte(8'hBC);
      check($sformatf("relock_active_bc%0d", n), active, (n == 4) ? 1 : 0);
    end

    // ALIGN abort then relock
    do_reset();
    send_byte(8'hBC);
    check("abort_active_bc1", active, 0);
    send_byte(8'hBC);
    check("abort_active_bc2", active, 0);
    send_byte(8'h55);
    check("abort_active_55", active, 0);
    check("abort_stb_55", stb_mid | byte_stb, 0);
    for (int n = 1; n <= 4; n++) begin
      send_byte(8'hBC);
      check($sformatf("abort_relock_bc%0d", n), active, (n == 4) ? 1 : 0);
    end
    send_byte(8'h3C);
    check("3c_stb", byte_stb, 1);
    check("3c_data", data_out, 8'h3C);
    check("3c_valid", valid_out, 1);

    // BC_LOCK = 1 lane
    do_reset();
    send_byte(8'hBC);
    check("lock1_active", active1, 1);
    check("lock1_stb", byte_stb1, 0);
    check("lock1_wide_active", active, 0);
    send_byte(8'hC3);
    check("lock1_c3_stb", byte_stb1, 1);
    check("lock1_c3_data", data_out1, 8'hC3);
    check("lock1_c3_valid", valid_out1, 1);
    send_bit(1'b0);
    check("lock1_stb_drop", byte_stb1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
